// File: rtl/exec_sequencer.sv
// Execution controller for the 8-bit MIPS datapath: turns step/run/halt controls into a one-clock dp_en.
// Optional macro BREAKPOINT_EN enables PC breakpoint halts in RUN.
module exec_sequencer #(
  parameter int unsigned RUN_DIV  = 4,
  parameter logic [3:0]  HALT_OPC = 4'hF,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_req,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic [7:0]       pc,
  input  logic [3:0]       opcode,
  input  logic [7:0]       bp_addr,
  input  logic             bp_valid,
  output logic             dp_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // state | meaning
  // IDLE  | waiting for a step edge or a run request
  // STEP  | single-step pulse cycle, dp_en high
  // RUN   | free-run, one pulse per RUN_DIV clocks
  // HALT  | stopped on HALT_OPC or breakpoint, waits for step or run release
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } seq_state_t;

  localparam logic [7:0] TC_VAL = 8'(RUN_DIV - 1);

  seq_state_t cur;
  logic [7:0] div_cnt;
  logic       step_q;
  logic       step_rise;
  logic       tc;
  logic       stop_run;
  logic       bp_hit;
  logic       halt_hit;

  assign step_rise = step_req & ~step_q;
  assign tc        = (div_cnt == TC_VAL);
  assign stop_run  = halt_req | ~run_req;

`ifdef BREAKPOINT_EN
  assign bp_hit = bp_valid & (pc == bp_addr);
`else
  // Breakpoint inputs are intentionally left unused in this build.
  logic unused_bp;
  assign unused_bp = &{1'b0, pc, bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  assign halt_hit = (opcode == HALT_OPC) | bp_hit;
  assign state    = cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur         <= S_IDLE;
      dp_en       <= 1'b0;
      div_cnt     <= 8'd0;
      step_q      <= 1'b0;
      instr_count <= '0;
      halted      <= 1'b0;
    end else begin
      step_q      <= step_req;
      instr_count <= instr_count + CNT_W'(dp_en);
      dp_en       <= 1'b0;
      halted      <= 1'b0;
      case (cur)
        S_IDLE: begin
          // run wins over a coincident step edge; that edge is dropped
          if (run_req && !halt_req) begin
            cur     <= S_RUN;
            div_cnt <= 8'd0;
          end else if (step_rise) begin
            cur   <= S_STEP;
            dp_en <= 1'b1;
          end
        end
        S_STEP: begin
          cur <= S_IDLE;
        end
        S_RUN: begin
          if (stop_run) begin
            cur     <= S_IDLE;
            div_cnt <= 8'd0;
          end else if (tc && halt_hit) begin
            cur     <= S_HALT;
            halted  <= 1'b1;
            div_cnt <= 8'd0;
          end else if (tc) begin
            dp_en   <= 1'b1;
            div_cnt <= 8'd0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_HALT: begin
          // no auto-restart: holding run_req keeps us parked here
          if (step_rise) begin
            cur   <= S_STEP;
            dp_en <= 1'b1;
          end else if (!run_req) begin
            cur <= S_IDLE;
          end else begin
            halted <= 1'b1;
          end
        end
        default: begin
          cur <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed scenarios plus randomized stimulus against a cycle-level model.
// Works with or without BREAKPOINT_EN defined.
module tb_exec_sequencer;
  localparam int          RUN_DIV  = 4;
  localparam int          CNT_W    = 4;
  localparam logic [3:0]  HALT_OPC = 4'hF;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             step_req = 1'b0;
  logic             run_req = 1'b0;
  logic             halt_req = 1'b0;
  logic [7:0]       pc = 8'd0;
  logic [3:0]       opcode = 4'd0;
  logic [7:0]       bp_addr = 8'd0;
  logic             bp_valid = 1'b0;
  logic             dp_en;
  logic [1:0]       state;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exec_sequencer #(
    .RUN_DIV (RUN_DIV),
    .HALT_OPC(HALT_OPC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .step_req   (step_req),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .pc         (pc),
    .opcode     (opcode),
    .bp_addr    (bp_addr),
    .bp_valid   (bp_valid),
    .dp_en      (dp_en),
    .state      (state),
    .halted     (halted),
    .instr_count(instr_count)
  );

  // Reference model: mode number plus cycles spent in RUN since entry.
  int               m_mode, m_runcyc, nx_mode, nx_runcyc;
  logic             m_dp, m_stepq, nx_dp, rise, tc_m, bp_m;
  logic [CNT_W-1:0] m_cnt;

  always_comb begin
    nx_mode   = m_mode;
    nx_runcyc = m_runcyc;
    nx_dp     = 1'b0;
    rise      = step_req && !m_stepq;
    tc_m      = (m_mode == 2) && ((m_runcyc % RUN_DIV) == RUN_DIV - 1);
`ifdef BREAKPOINT_EN
    bp_m      = bp_valid && (pc == bp_addr);
`else
    bp_m      = 1'b0;
`endif
    case (m_mode)
      0: begin
        if (run_req && !halt_req) begin
          nx_mode   = 2;
          nx_runcyc = 0;
        end else if (rise) begin
          nx_mode = 1;
          nx_dp   = 1'b1;
        end
      end
      1: nx_mode = 0;
      2: begin
        nx_runcyc = m_runcyc + 1;
        if (halt_req || !run_req) nx_mode = 0;
        else if (tc_m && (opcode == HALT_OPC || bp_m)) nx_mode = 3;
        else if (tc_m) nx_dp = 1'b1;
      end
      default: begin
        if (rise) begin
          nx_mode = 1;
          nx_dp   = 1'b1;
        end else if (!run_req) begin
          nx_mode = 0;
        end
      end
    endcase
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode   <= 0;
      m_runcyc <= 0;
      m_dp     <= 1'b0;
      m_stepq  <= 1'b0;
      m_cnt    <= '0;
    end else begin
      m_mode   <= nx_mode;
      m_runcyc <= nx_runcyc;
      m_dp     <= nx_dp;
      m_stepq  <= step_req;
      m_cnt    <= m_cnt + CNT_W'(m_dp);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model_state", int'(state), m_mode);
    check("model_dp_en", int'(dp_en), int'(m_dp));
    check("model_halted", int'(halted), int'(m_mode == 3));
    check("model_count", int'(instr_count), int'(m_cnt));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
    end
  endtask

  task automatic count_pulses(input int n, output int s);
    s = 0;
    repeat (n) begin
      cyc(1);
      s += int'(dp_en);
    end
  endtask

  initial begin
    int s;
    #1 rst = 1'b0;
    cyc(2);
    check("reset_state", int'(state), 0);
    check("reset_dp_en", int'(dp_en), 0);
    check("reset_count", int'(instr_count), 0);
    rst = 1'b1;
    cyc(1);

    // three separate steps
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      cyc(1);
      check("step_pulse", int'(dp_en), 1);
      check("step_state", int'(state), 1);
      step_req = 1'b0;
      cyc(1);
      check("step_return", int'(state), 0);
      cyc(1);
    end
    check("three_steps_count", int'(instr_count), 3);

    // held step gives a single pulse
    step_req = 1'b1;
    count_pulses(50, s);
    check("held_step_pulses", s, 1);
    step_req = 1'b0;
    cyc(2);
    check("held_step_count", int'(instr_count), 4);

    // free run: four pulses in 17 clocks, then halt_req
    opcode  = 4'h1;
    run_req = 1'b1;
    cyc(1);
    check("run_enter", int'(state), 2);
    count_pulses(17, s);
    check("run_pulses", s, 4);
    halt_req = 1'b1;
    cyc(1);
    check("halt_req_idle", int'(state), 0);
    count_pulses(5, s);
    check("halt_req_no_pulse", s, 0);
    run_req  = 1'b0;
    halt_req = 1'b0;
    cyc(1);
    check("run_count", int'(instr_count), 8);

    // HALT opcode at pc 5
    opcode  = 4'hF;
    pc      = 8'h05;
    run_req = 1'b1;
    cyc(1);
    count_pulses(4, s);
    check("halt_opc_state", int'(state), 3);
    check("halt_opc_halted", int'(halted), 1);
    check("halt_opc_no_pulse", s, 0);
    cyc(3);
    check("halt_stays", int'(state), 3);
    run_req = 1'b0;
    cyc(1);
    check("halt_release", int'(state), 0);
    run_req = 1'b1;
    cyc(5);
    check("halt_again", int'(state), 3);
    step_req = 1'b1;
    cyc(1);
    check("halt_step_pulse", int'(dp_en), 1);
    check("halt_step_state", int'(state), 1);
    step_req = 1'b0;
    run_req  = 1'b0;
    cyc(1);
    check("halt_step_idle", int'(state), 0);
    check("halt_step_count", int'(instr_count), 9);

    // breakpoint at pc 0x10
    opcode   = 4'h2;
    pc       = 8'h10;
    bp_addr  = 8'h10;
    bp_valid = 1'b1;
    run_req  = 1'b1;
    cyc(5);
`ifdef BREAKPOINT_EN
    check("bp_halt_state", int'(state), 3);
    check("bp_halt_dp", int'(dp_en), 0);
`else
    check("bp_ignored_state", int'(state), 2);
    check("bp_ignored_dp", int'(dp_en), 1);
`endif
    run_req  = 1'b0;
    bp_valid = 1'b0;
    cyc(2);

    // asynchronous reset mid-run
    run_req = 1'b1;
    cyc(7);
    check("pre_reset_state", int'(state), 2);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_dp", int'(dp_en), 0);
    check("async_rst_count", int'(instr_count), 0);
    cyc(1);
    run_req = 1'b0;
    rst     = 1'b1;
    cyc(1);

    // counter wrap at 4 bits
    for (int i = 0; i < 16; i++) begin
      step_req = 1'b1;
      cyc(1);
      step_req = 1'b0;
      cyc(1);
      if (i == 14) check("count_15", int'(instr_count), 15);
    end
    check("count_wrap", int'(instr_count), 0);

    // randomized stimulus
    bp_addr = 8'h03;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 30) step_req = ~step_req;
      if ($urandom_range(0, 99) < 8) run_req = ~run_req;
      halt_req = ($urandom_range(0, 99) < 4);
      opcode   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      pc       = 8'($urandom_range(0, 7));
      bp_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
      end
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Execution controller for the 8-bit MIPS datapath. It replaces the raw debounced push-button clock with a one-cycle datapath enable (dp_en) on the free-running board clock. It supports three ways of advancing the datapath: single-step, free-run at a divided rate, and automatic halt on a HALT opcode or PC breakpoint. It sits between the debouncer/VIO controls and the enables of the register file, data memory, program counter and instruction memory.

Parameters:
RUN_DIV, 4, clk cycles between dp_en pulses in RUN; legal range 1..255
HALT_OPC, 4'hF, opcode value that stops RUN
CNT_W, 16, width of instr_count

Ports:
clk  in  1  board clock; all state is on its rising edge
rst  in  1  reset, asynchronous, active-low
step_req  in  1  debounced step button (level); its rising edge requests one step
run_req  in  1  level; 1 requests free-run
halt_req  in  1  level; 1 forces stop from RUN
pc  in  8  current program counter value
opcode  in  4  opcode of the instruction at pc
bp_addr  in  8  breakpoint address
bp_valid  in  1  breakpoint armed
dp_en  out  1  registered; one-clk datapath advance pulse
state  out  2  0=IDLE 1=STEP 2=RUN 3=HALT
halted  out  1  1 while in HALT
instr_count  out  CNT_W  number of dp_en pulses issued

Behaviour:
- Reset (rst=0, async): state=IDLE, dp_en=0, div_cnt=0, step_q=0, instr_count=0, halted=0.
- Edge detect: step_q <= step_req; step_rise = step_req & ~step_q.
- IDLE:
  - run_req=1 and halt_req=0 -> RUN, with div_cnt cleared to 0.
  - Otherwise, step_rise -> STEP.
  - run_req has priority; a simultaneous step_rise is dropped.
- STEP: dp_en=1 for exactly this one cycle. Next state is IDLE, unconditionally.
- RUN: div_cnt counts 0..RUN_DIV-1 and wraps. "tc" means div_cnt==RUN_DIV-1. Evaluate in priority order:
  1. halt_req=1 -> IDLE. No pulse. div_cnt cleared.
  2. tc and opcode==HALT_OPC -> HALT. Pulse suppressed.
  3. tc and breakpoint hit -> HALT. Pulse suppressed.
  4. tc -> dp_en=1 next cycle. Stay in RUN.
  - RUN_DIV=1: dp_en is high every cycle while in RUN.
  - run_req falling to 0 behaves as halt_req.
- HALT: dp_en=0, halted=1.
  - step_rise -> STEP. The instruction at the halt PC executes; the next state is IDLE.
  - run_req=0 -> IDLE.
  - If both occur in the same cycle, step_rise wins.
  - run_req held at 1 with no step keeps the block in HALT, so there is no automatic restart.
- dp_en is registered and glitch-free. Latency from the STEP decision, or from tc, to dp_en is 1 clk.
- instr_count increments on every cycle with dp_en=1 and wraps from all-ones to 0.
- step_req held high produces only one step; a new rising edge is required for the next.
- Reset mid-RUN or mid-STEP aborts immediately; a pending pulse is lost.
- Inputs pc, opcode and bp_* are sampled only at tc in RUN. They are don't-care otherwise.

Optional Feature:
BREAKPOINT_EN
- Defined: "breakpoint hit" = bp_valid & (pc==bp_addr), as in rule 3.
- Undefined: bp_addr and bp_valid are ignored (left unconnected internally), rule 3 never fires, and only HALT_OPC, halt_req and run_req stop RUN.

Test Plan:
1. Reset, then 3 separate step_req rising edges from IDLE -> exactly 3 single-cycle dp_en pulses; instr_count=3; state returns to 0 after each.
2. step_req held high for 50 clk -> exactly 1 dp_en pulse; instr_count +1.
3. RUN_DIV=4, run_req=1 for 17 clk after entering RUN, opcode≠HALT_OPC -> dp_en pulses every 4th cycle, 4 pulses total; halt_req=1 -> state=IDLE next clk, no further pulses.
4. RUN with opcode=4'hF presented at pc=8'h05 -> state=3, halted=1, no pulse for that instruction. Drop run_req -> state=0. Alternatively, a step from HALT gives 1 pulse and state=0.
5. BREAKPOINT_EN defined, bp_valid=1, bp_addr=8'h10, pc reaches 8'h10 in RUN -> HALT, pulse suppressed. Same stimulus with the macro undefined -> no halt, pulse issued.
6. Assert rst mid-RUN -> dp_en=0, instr_count=0, state=0 asynchronously. With CNT_W=4 and 16 steps -> instr_count wraps to 0.
